// File: rtl/watch_pkg.sv
// watch_pkg: constants shared across the watch front-panel logic.
// Holds the beep FSM state encoding and the default beep timing used by
// both beep_drv and the alarm logic.
package watch_pkg;

  // State encoding for the beep driver FSM
  localparam logic [1:0] BEEP_IDLE = 2'b00;
  localparam logic [1:0] BEEP_ON   = 2'b01;
  localparam logic [1:0] BEEP_OFF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = BEEP_IDLE,
    ST_ON   = BEEP_ON,
    ST_OFF  = BEEP_OFF
  } beep_state_t;

  // Default beep timing (clk cycles / beeps per burst)
  localparam int BEEP_ON_CYC_DEF  = 100;
  localparam int BEEP_OFF_CYC_DEF = 100;
  localparam int BEEP_BURST_DEF   = 3;

  // Larger of two integers, used for sizing the shared cycle counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/beep_timer.sv
// beep_timer: loadable up-counter with a terminal-count flag.
// The terminal value is supplied by the caller so one counter can time
// phases of different lengths. Asynchronous active-low reset.
module beep_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Counter register: load has priority over count enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en)
      cnt <= cnt + W'(1);
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/beep_drv.sv
// beep_drv: turns single-cycle tick pulses into timed bursts of beeps on
// an active-low buzzer output.
// Optional feature macro: BEEP_RETRIG_EN -- when defined, a tick during a
// burst restarts the burst; otherwise such ticks are dropped.
module beep_drv
  import watch_pkg::*;
#(
  parameter int ON_CYC  = BEEP_ON_CYC_DEF,
  parameter int OFF_CYC = BEEP_OFF_CYC_DEF,
  parameter int BURST   = BEEP_BURST_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  output logic bzn,
  output logic busy
);

  localparam int CW = $clog2(max_int(ON_CYC, OFF_CYC) + 1);
  localparam int BW = $clog2(BURST + 1);

  localparam logic [CW-1:0] ON_TC     = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_TC    = CW'(OFF_CYC - 1);
  localparam logic [BW-1:0] LAST_BEEP = BW'(BURST - 1);

  // Zero-valued timing parameters would make the counters meaningless
  if (ON_CYC < 1 || OFF_CYC < 1 || BURST < 1) begin : g_bad_param
    $error("beep_drv: ON_CYC, OFF_CYC and BURST must all be >= 1");
  end

  beep_state_t   state_reg, state_next;
  logic [BW-1:0] bcnt_reg, bcnt_next;

  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_tc;
  logic [CW-1:0] tmr_tc_val;
  logic [CW-1:0] cnt_val;

  // The terminal count follows the phase currently being timed
  assign tmr_tc_val = (state_reg == ST_ON) ? ON_TC : OFF_TC;

  beep_timer #(.W(CW)) cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val ('0),
    .tc_val   (tmr_tc_val),
    .cnt      (cnt_val),
    .tc       (tmr_tc)
  );

  // State and beep-count registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  // Next-state, beep count and cycle-timer control
  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Hold the timer at zero so every burst starts from a clean count
        tmr_load = 1'b1;
        if (tick) begin
          state_next = ST_ON;
          bcnt_next  = '0;
        end
      end
      ST_ON: begin
        if (tmr_tc) begin
          tmr_load   = 1'b1;
          bcnt_next  = bcnt_reg + BW'(1);
          // No trailing gap after the final beep
          state_next = (bcnt_reg == LAST_BEEP) ? ST_IDLE : ST_OFF;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_OFF: begin
        if (tmr_tc) begin
          tmr_load   = 1'b1;
          state_next = ST_ON;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        tmr_load   = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
`ifdef BEEP_RETRIG_EN
    // A tick mid-burst restarts the burst from the first beep
    if (tick && (state_reg != ST_IDLE)) begin
      state_next = ST_ON;
      bcnt_next  = '0;
      tmr_load   = 1'b1;
      tmr_en     = 1'b0;
    end
`endif
  end

  // Outputs decode the state register only, so tick never reaches the pin
  assign bzn  = (state_reg != ST_ON);
  assign busy = (state_reg != ST_IDLE);

endmodule
